// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational
// instruction memory, buffers words in a 2-entry prefetch queue and hands
// them to decode over a valid/ready handshake. Handles redirects, halt and
// sticky address faults.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instrn_address,
    input  logic [31:0] instrn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instrn,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_e      state_q;
    logic        fault_q;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    entry_t      q0_q, q0_d;       // queue head
    entry_t      q1_q, q1_d;       // second entry
    logic [1:0]  count_q, count_d;

    logic   pop;
    logic   push;
    logic   flush;
    logic   pc_out_of_range;
    entry_t new_entry;

    // A word fetch is legal only if all four bytes lie inside the memory;
    // the 33-bit sum keeps addresses near 2^32 from wrapping into range.
    function automatic logic out_of_range(input logic [31:0] pc);
        return ({1'b0, pc} + 33'd3) >= 33'(MEM_BYTES);
    endfunction

    function automatic logic bad_target(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || out_of_range(pc);
    endfunction

    assign instrn_address  = fetch_pc_q;
    assign out_valid       = (count_q != 2'd0);
    assign out_instrn      = out_valid ? q0_q.instr : 32'h0;
    assign out_pc          = out_valid ? q0_q.pc    : 32'h0;
    assign fault           = fault_q;
    assign state_o         = state_q;

    assign pop             = out_valid && out_ready;
    assign flush           = redirect_valid && (state_q != ST_FAULT);
    assign pc_out_of_range = out_of_range(fetch_pc_q);
    // Fetch also proceeds in HALT during the cycle halt drops, so the
    // condition is "not faulted and halt low" rather than "in FETCH".
    assign push            = (state_q != ST_FAULT) && !flush && !halt && !pc_out_of_range
                             && ((count_q != 2'(QDEPTH)) || pop);
    assign new_entry       = '{pc: fetch_pc_q, instr: instrn};

    // Control FSM: tracks fetch/halt/fault and the sticky fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            state_q <= ST_FETCH;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH, ST_HALT: begin
                    if (flush) begin
                        // Redirect keeps the current mode unless the target is bad.
                        if (bad_target(redirect_pc)) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end
                    end else if (halt) begin
                        state_q <= ST_HALT;
                    end else if (pc_out_of_range) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
                default: begin
                    state_q <= ST_FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    // Next-state for fetch PC and the shift-style prefetch queue.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        fetch_pc_d = fetch_pc_q;
        q0_d       = q0_q;
        q1_d       = q1_q;
        count_d    = count_q;

        if (flush) begin
            fetch_pc_d = redirect_pc;
            q0_d       = '0;
            q1_d       = '0;
            count_d    = 2'd0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            unique case ({push, pop})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        q0_d = new_entry;
                    end else begin
                        q0_d = q1_q;
                        q1_d = new_entry;
                    end
                end
                2'b01: begin
                    q0_d    = q1_q;
                    q1_d    = '0;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        q0_d = new_entry;
                    end else begin
                        q1_d = new_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the queue storage is reset along with the count so the head
        // registers never expose stale words after reset; it is only two
        // entries, so there is no memory macro to worry about.
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            q0_q       <= '0;
            q1_q       <= '0;
            count_q    <= 2'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            count_q    <= count_d;
        end
    end

endmodule
